// File: rtl/adder_pkg.sv
// adder_pkg: op encoding, depth limit and saturation-limit helpers for pipelined_adder.
package adder_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int MAX_STAGES = 4;
  function automatic logic smax_bit(input int i, input int len);
    return i != len - 1;
  endfunction
  function automatic logic smin_bit(input int i, input int len);
    return i == len - 1;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: W-bit ripple slice with carry-in and carry-out, one per pipeline stage.
module adder_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep sliced add/sub with valid/ready, carry/overflow/zero flags.
// Optional clamp-on-overflow with a sat input when PIPE_ADDER_SAT_EN is defined.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int LENGTH = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] A,
  input  logic [LENGTH-1:0] B,
  input  logic              sub,
  input  logic              is_signed,
`ifdef PIPE_ADDER_SAT_EN
  input  logic              sat,
`endif
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] Result,
  output logic              carry_out,
  output logic              overflow,
  output logic              zero
);
  localparam int W = LENGTH / STAGES;
  localparam int M = LENGTH - 1;
  logic [STAGES-1:0] v_q;
  logic [STAGES:0] v_sh;
  logic adv, sat_in;
`ifdef PIPE_ADDER_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif
  // Global enable: every stage shifts together, bubbles are kept.
  assign adv = ~v_q[STAGES-1] | out_ready;
  assign in_ready = adv & ~flush;
  assign out_valid = v_q[STAGES-1];
  assign v_sh = {v_q, in_valid};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v_q <= '0;
    else if (flush) v_q <= '0;
    else if (adv) v_q <= v_sh[STAGES-1:0];
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [LENGTH-1:0] a_d, b_d, r_i, r_d;
    logic [W-1:0] s;
    logic c_i, c_d, sg_d, sb_d, st_d;
    if (k == 0) begin : g_in
      assign a_d = A;
      assign b_d = (sub == OP_SUB) ? ~B : B;
      assign r_i = '0;
      assign c_i = sub;
      assign sg_d = is_signed;
      assign sb_d = sub;
      assign st_d = sat_in;
    end else begin : g_fwd
      assign a_d = g_st[k-1].g_p.a_q;
      assign b_d = g_st[k-1].g_p.b_q;
      assign r_i = g_st[k-1].g_p.r_q;
      assign c_i = g_st[k-1].g_p.c_q;
      assign sg_d = g_st[k-1].g_p.sg_q;
      assign sb_d = g_st[k-1].g_p.sb_q;
      assign st_d = g_st[k-1].g_p.st_q;
    end
    adder_slice #(.W(W)) u_slice (
      .a_i   (a_d[k*W +: W]),
      .b_i   (b_d[k*W +: W]),
      .cin_i (c_i),
      .sum_o (s),
      .cout_o(c_d)
    );
    always_comb begin
      r_d = r_i;
      r_d[k*W +: W] = s;
    end
    if (k < STAGES - 1) begin : g_p
      logic [LENGTH-1:0] a_q, b_q, r_q;
      logic c_q, sg_q, sb_q, st_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {a_q, b_q, r_q, c_q, sg_q, sb_q, st_q} <= '0;
        else if (adv) {a_q, b_q, r_q, c_q, sg_q, sb_q, st_q} <= {a_d, b_d, r_d, c_d, sg_d, sb_d, st_d};
    end else begin : g_o
      logic [LENGTH-1:0] lim, res, r_q;
      logic ov, c_q, ov_q, z_q;
      // Positive signed overflow only happens with A[MSB] = 0, so A's sign picks the limit.
      always_comb begin
        ov = sg_d ? (a_d[M] == b_d[M]) && (r_d[M] != a_d[M]) : (sb_d ? ~c_d : c_d);
        for (int i = 0; i < LENGTH; i++)
          lim[i] = sg_d ? (a_d[M] ? smin_bit(i, LENGTH) : smax_bit(i, LENGTH)) : ~sb_d;
        res = (st_d && ov) ? lim : r_d;
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {r_q, c_q, ov_q, z_q} <= '0;
        else if (adv) {r_q, c_q, ov_q, z_q} <= {res, c_d, ov, res == '0};
    end
  end
  assign Result = g_st[STAGES-1].g_o.r_q;
  assign carry_out = g_st[STAGES-1].g_o.c_q;
  assign overflow = g_st[STAGES-1].g_o.ov_q;
  assign zero = g_st[STAGES-1].g_o.z_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vector table plus backpressure, flush and reset sequences.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, sub, is_signed, flush, sat;
  logic out_valid, out_ready, carry_out, overflow, zero;
  logic [31:0] A, B, Result;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [31:0] a, b;
    logic sub, sg;
    logic [31:0] r;
    logic c, o, z;
  } vec_t;
  vec_t tv [10];
  always #5 clk = ~clk;
  pipelined_adder #(.LENGTH(32), .STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .sub      (sub),
    .is_signed(is_signed),
`ifdef PIPE_ADDER_SAT_EN
    .sat      (sat),
`endif
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .carry_out(carry_out),
    .overflow (overflow),
    .zero     (zero)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    A = v.a; B = v.b; sub = v.sub; is_signed = v.sg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, 2);
    chk({nm, "_res"}, Result, v.r);
    chk({nm, "_carry"}, carry_out, v.c);
    chk({nm, "_ovf"}, overflow, v.o);
    chk({nm, "_zero"}, zero, v.z);
    @(posedge clk); #1;
  endtask
  initial begin
    int sent, got, cyc;
    logic stalled;
    logic [31:0] held;
    vec_t sv;
    tv[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tv[1] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
    tv[2] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tv[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tv[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tv[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tv[6] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tv[7] = '{32'h12345678, 32'h12345679, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    tv[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tv[9] = '{32'h00000003, 32'h00000002, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b0; in_valid = 1'b1; A = 32'h1234; B = 32'h1; sub = 1'b0; is_signed = 1'b0;
    flush = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", Result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) run_vec(tv[i], $sformatf("vec%0d", i));
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid = sent < 6; A = sent; B = 32'h100; sub = 1'b0; is_signed = 1'b0;
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (!out_ready) begin
        chk("bp_stall_in_ready", in_ready, 0);
        if (stalled) chk("bp_stall_hold", Result, held);
        held = Result;
        stalled = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_result%0d", got), Result, got + 32'h100);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", got, 6);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_dup", out_valid, 0);
    A = 32'h10; B = 32'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 32'h11;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("flush_quiet%0d", i), out_valid, 0);
      @(posedge clk); #1;
    end
    sv = '{32'h00000040, 32'h00000002, 1'b0, 1'b0, 32'h00000042, 1'b0, 1'b0, 1'b0};
    run_vec(sv, "post_flush");
`ifdef PIPE_ADDER_SAT_EN
    sat = 1'b1;
    sv = '{32'h7FFFFFF0, 32'h00000020, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    run_vec(sv, "sat_on");
    sat = 1'b0;
    sv = '{32'h7FFFFFF0, 32'h00000020, 1'b0, 1'b1, 32'h80000010, 1'b0, 1'b1, 1'b0};
    run_vec(sv, "sat_off");
`endif
    A = 32'h7; B = 32'h8; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", Result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit with carry, signed/unsigned overflow and zero flags, and a valid/ready handshake on both sides. The carry chain is split into STAGES registered slices, so wide operands close timing in the multicycle/pipelined datapath. It replaces the single-cycle combinational adder wherever the ALU result can tolerate STAGES cycles of latency.

## Interface
- LENGTH, 32: operand/result width; must be divisible by STAGES.
- STAGES, 2: pipeline depth = latency in cycles; legal 1..4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- A  in  LENGTH  operand A.
- B  in  LENGTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- is_signed  in  1  selects the overflow rule (two's complement or unsigned).
- flush  in  1  synchronously discard all in-flight beats.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- Result  out  LENGTH  sum or difference, modulo 2^LENGTH.
- carry_out  out  1  carry out of the MSB; for sub, 1 = no borrow.
- overflow  out  1  overflow per the is_signed rule.
- zero  out  1  Result == 0.

## Operation
- Subtraction: B is inverted and carry-in is 1. Addition: carry-in is 0.
- Slice width is W = LENGTH/STAGES.
  - Stage k adds bits [kW+W−1:kW] using the registered carry from stage k−1.
  - Already-computed lower slices and the upper operand slices ride along in the pipeline registers.
- Overflow, evaluated in the last stage:
  - Signed: A[MSB] == B'[MSB] and Result[MSB] != A[MSB], where B' is the post-inversion operand.
  - Unsigned add: carry_out.
  - Unsigned sub: ~carry_out.
- Pipeline advance: adv = ~valid[STAGES−1] | out_ready.
  - adv is a global enable: all stages shift together, and bubbles are not collapsed.
- in_ready = adv & ~flush. A beat is accepted when in_valid & in_ready.
- out_valid = valid[STAGES−1]. Result and flags are registered and stay stable while out_valid & ~out_ready.
- Flush:
  - Clears every valid bit on the next edge. Data registers are not cleared.
  - A flush in the same cycle as in_valid drops that beat, because in_ready is 0.
  - Flush has priority over out_ready.
- Reset (async assert, sync-deasserted externally): all valid bits, Result and flags go to 0. in_ready is 1 on the first cycle after reset.

## Timing
- Latency is exactly STAGES cycles from acceptance to out_valid, assuming no stall.
- Throughput is 1 beat/cycle while out_ready stays high.
- A stall holds every stage. No beat is lost or reordered.
- Simultaneous last-stage pop and first-stage push in the same cycle is legal and required.
- STAGES = 1 is a single registered adder: out_valid follows an accept by 1 cycle.
- Reset mid-operation: all in-flight beats are lost, and out_valid drops immediately (asynchronously).

## Configuration
- PIPE_ADDER_SAT_EN defined:
  - Adds input port sat (1 bit, timed with A/B).
  - When sat = 1 and overflow = 1, Result is clamped:
    - signed positive overflow → 0x7FF…F;
    - signed negative overflow → 0x800…0;
    - unsigned add → all ones;
    - unsigned sub → 0.
  - zero reflects the clamped value. overflow still reads 1.
- PIPE_ADDER_SAT_EN not defined: there is no sat port, and Result always wraps modulo 2^LENGTH.

## Structure
- Package adder_pkg holds:
  - the op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - MAX_STAGES = 4;
  - the saturation limit helper functions for signed max/min.
- Sub-module adder_slice: a W-bit adder with carry-in, producing sum and carry-out, instantiated once per stage.
- The top level owns the valid shift register, operand/result pipeline registers, flag logic and saturation.

## Test plan
All scenarios use LENGTH = 32, STAGES = 2.
- Reset: hold rst_n low 3 cycles with in_valid = 1 → out_valid = 0, Result = 0, flags = 0; in_ready = 1 on the first cycle after release.
- Signed add overflow: A = 0x7FFFFFFF, B = 1, is_signed = 1 → 2 cycles later Result = 0x80000000, overflow = 1, carry_out = 0, zero = 0.
- Unsigned sub borrow: A = 0, B = 1, sub = 1, is_signed = 0 → Result = 0xFFFFFFFF, carry_out = 0, overflow = 1; then A = 5, B = 5 → Result = 0, zero = 1, carry_out = 1.
- Backpressure: stream 6 beats computing i + 0x100; drop out_ready for 3 cycles mid-stream → in_ready = 0 while stalled, all 6 results appear in order, with no duplicates.
- Flush: accept 2 beats, assert flush on the next cycle with in_valid = 1 → no out_valid for the following 4 cycles; the next accepted beat emerges with correct latency.
- PIPE_ADDER_SAT_EN: A = 0x7FFFFFF0, B = 0x20, signed, sat = 1 → Result = 0x7FFFFFFF, overflow = 1; same case with sat = 0 → Result = 0x80000010.
